// File: rtl/multicycle_seq.sv
// multicycle_seq: control sequencer for a multicycle processor datapath.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   instr_index  one-hot decoded instruction (bits 0..30), bit 31 unused
//   z            ALU zero flag, used by beq/bne in EXEC
//   mem_ack      memory completion, honoured only while mem_req=1
//   state        current state encoding
//   mem_req      memory access request
//   mem_we       memory write (store)
//   ir_we        instruction register load strobe
//   pc_we        PC write strobe
//   pc_sel       next-PC source: 0=PC+4, 1=branch, 2=jump, 3=register (jr)
//   rf_we        register file write strobe
//   trap         illegal-instruction indication (sticky until reset)
//   instret      retired instruction count, wraps
//
// state  | meaning
// FETCH  | request instruction word, wait for mem_ack, load IR, PC+4
// DECODE | legality check, jumps resolved here
// EXEC   | ALU step, branch resolution
// MEM    | load/store access, wait for mem_ack
// WB     | register file write, single cycle
// TRAP   | illegal instruction seen, parked until reset
module multicycle_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_index,
  input  logic        z,
  input  logic        mem_ack,
  output logic [2:0]  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic        trap,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam int B_JR  = 16;
  localparam int B_LW  = 22;
  localparam int B_SW  = 23;
  localparam int B_BEQ = 24;
  localparam int B_BNE = 25;
  localparam int B_J   = 29;
  localparam int B_JAL = 30;

  localparam logic [1:0] SEL_PC4 = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_JMP = 2'd2;
  localparam logic [1:0] SEL_REG = 2'd3;

  state_t      state_q, state_d;
  // running_q keeps mem_req low while reset is held and releases it on the
  // first clock edge afterwards, so FETCH cannot accept a stale ack.
  logic        running_q;
  logic [31:0] instret_q;
  // Only the classes needed after DECODE are kept: {bne, beq, sw, lw}.
  logic [3:0]  ir_q;
  logic        retire;
  logic        legal;
  logic        taken;
  logic [30:0] instr_low;

  assign instr_low = instr_index[30:0];
  // Exactly one of bits 0..30 set and bit 31 clear.
  assign legal = !instr_index[31] && (instr_low != '0) &&
                 ((instr_low & (instr_low - 31'd1)) == '0);
  assign taken = (ir_q[2] & z) | (ir_q[3] & ~z);

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = SEL_PC4;
    rf_we   = 1'b0;
    trap    = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = running_q;
        if (running_q && mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = SEL_PC4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_TRAP;
        end else if (instr_index[B_J]) begin
          pc_we   = 1'b1;
          pc_sel  = SEL_JMP;
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (instr_index[B_JR]) begin
          pc_we   = 1'b1;
          pc_sel  = SEL_REG;
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (instr_index[B_JAL]) begin
          pc_we   = 1'b1;
          pc_sel  = SEL_JMP;
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ir_q[2] || ir_q[3]) begin
          // pc_sel stays 0 on a not-taken branch so it never shows without pc_we.
          pc_we   = taken;
          pc_sel  = taken ? SEL_BR : SEL_PC4;
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (ir_q[0] || ir_q[1]) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = ir_q[1];
        if (mem_ack) begin
          if (ir_q[1]) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        // Unused encodings are treated like an illegal instruction.
        state_d = S_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      running_q <= 1'b0;
      instret_q <= '0;
      ir_q      <= '0;
    end else begin
      running_q <= 1'b1;
      state_q   <= state_d;
      if (state_q == S_DECODE)
        ir_q <= {instr_index[B_BNE], instr_index[B_BEQ],
                 instr_index[B_SW], instr_index[B_LW]};
      if (retire)
        instret_q <= instret_q + 32'd1;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_seq.sv
module tb_multicycle_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_index;
  logic        z;
  logic        mem_ack;
  logic [2:0]  state;
  logic        mem_req, mem_we, ir_we, pc_we, rf_we, trap;
  logic [1:0]  pc_sel;
  logic [31:0] instret;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_seq dut (
    .clk(clk), .rst_n(rst_n), .instr_index(instr_index), .z(z),
    .mem_ack(mem_ack), .state(state), .mem_req(mem_req), .mem_we(mem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  logic [10:0] outs;
  assign outs = {state, mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, trap};

  function automatic logic [10:0] o(input int st, input bit req, input bit we,
                                    input bit irw, input bit pcw, input int sel,
                                    input bit rf, input bit tr);
    return {st[2:0], req, we, irw, pcw, sel[1:0], rf, tr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply ack/z for one cycle, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input bit ack_v, input bit z_v, input logic [10:0] exp);
    mem_ack = ack_v;
    z = z_v;
    #1;
    chk(tag, {21'd0, outs}, {21'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ack = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Common expected output vectors.
  logic [10:0] F_WAIT, F_ACK, DEC, EXE, WB, TRP, M_LD, M_ST, IDLE;

  initial begin
    F_WAIT = o(0, 1, 0, 0, 0, 0, 0, 0);
    F_ACK  = o(0, 1, 0, 1, 1, 0, 0, 0);
    DEC    = o(1, 0, 0, 0, 0, 0, 0, 0);
    EXE    = o(2, 0, 0, 0, 0, 0, 0, 0);
    M_LD   = o(3, 1, 0, 0, 0, 0, 0, 0);
    M_ST   = o(3, 1, 1, 0, 0, 0, 0, 0);
    WB     = o(4, 0, 0, 0, 0, 0, 1, 0);
    TRP    = o(5, 0, 0, 0, 0, 0, 0, 1);
    IDLE   = o(0, 0, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0; instr_index = 32'd0; z = 1'b0; mem_ack = 1'b1;
    #12;
    chk("rst_outs", {21'd0, outs}, {21'd0, IDLE});
    chk("rst_instret", instret, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_first_req", {31'd0, mem_req}, 32'd1);

    // add, ack tied high
    instr_index = 32'h1;
    cyc("add_f", 1, 0, F_ACK);
    cyc("add_d", 1, 0, DEC);
    cyc("add_e", 1, 0, EXE);
    cyc("add_wb", 1, 0, WB);
    chk("add_back", {29'd0, state}, 32'd0);
    chk("add_instret", instret, 32'd1);

    // lw, ack on third cycle of FETCH and of MEM; WB is cycle 9
    instr_index = 32'h1 << 22;
    cyc("lw_f1", 0, 0, F_WAIT);
    cyc("lw_f2", 0, 0, F_WAIT);
    cyc("lw_f3", 1, 0, F_ACK);
    cyc("lw_d", 1, 0, DEC);
    cyc("lw_e", 1, 0, EXE);
    cyc("lw_m1", 0, 0, M_LD);
    cyc("lw_m2", 0, 0, M_LD);
    cyc("lw_m3", 1, 0, M_LD);
    cyc("lw_wb", 0, 0, WB);
    chk("lw_instret", instret, 32'd2);

    // sw
    instr_index = 32'h1 << 23;
    cyc("sw_f", 1, 0, F_ACK);
    cyc("sw_d", 0, 0, DEC);
    cyc("sw_e", 0, 0, EXE);
    cyc("sw_m1", 0, 0, M_ST);
    cyc("sw_m2", 1, 0, M_ST);
    chk("sw_back", {29'd0, state}, 32'd0);
    chk("sw_instret", instret, 32'd3);

    // branches
    instr_index = 32'h1 << 24;
    cyc("beq1_f", 1, 0, F_ACK);
    cyc("beq1_d", 1, 0, DEC);
    cyc("beq1_e", 1, 1, o(2, 0, 0, 0, 1, 1, 0, 0));
    cyc("beq0_f", 1, 0, F_ACK);
    cyc("beq0_d", 1, 0, DEC);
    cyc("beq0_e", 1, 0, EXE);
    instr_index = 32'h1 << 25;
    cyc("bne0_f", 1, 0, F_ACK);
    cyc("bne0_d", 1, 0, DEC);
    cyc("bne0_e", 1, 0, o(2, 0, 0, 0, 1, 1, 0, 0));
    cyc("bne1_f", 1, 1, F_ACK);
    cyc("bne1_d", 1, 1, DEC);
    cyc("bne1_e", 1, 1, EXE);
    chk("br_instret", instret, 32'd7);

    // jumps
    instr_index = 32'h1 << 29;
    cyc("j_f", 1, 0, F_ACK);
    cyc("j_d", 1, 0, o(1, 0, 0, 0, 1, 2, 0, 0));
    instr_index = 32'h1 << 16;
    cyc("jr_f", 1, 0, F_ACK);
    cyc("jr_d", 1, 0, o(1, 0, 0, 0, 1, 3, 0, 0));
    instr_index = 32'h1 << 30;
    cyc("jal_f", 1, 0, F_ACK);
    cyc("jal_d", 1, 0, o(1, 0, 0, 0, 1, 2, 0, 0));
    cyc("jal_wb", 1, 0, WB);
    chk("jmp_instret", instret, 32'd10);

    // instret wrap: preset while FETCH is stalled, then retire one add
    instr_index = 32'h1;
    mem_ack = 1'b0;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    chk("wrap_preset", instret, 32'hFFFF_FFFF);
    cyc("wrap_f0", 0, 0, F_WAIT);
    cyc("wrap_f", 1, 0, F_ACK);
    cyc("wrap_d", 1, 0, DEC);
    cyc("wrap_e", 1, 0, EXE);
    cyc("wrap_wb", 1, 0, WB);
    chk("wrap_instret", instret, 32'd0);

    // reset in the middle of a store
    instr_index = 32'h1 << 23;
    cyc("rmem_f", 1, 0, F_ACK);
    cyc("rmem_d", 0, 0, DEC);
    cyc("rmem_e", 0, 0, EXE);
    mem_ack = 1'b0;
    #1;
    chk("rmem_in_mem", {21'd0, outs}, {21'd0, M_ST});
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmem_outs", {21'd0, outs}, {21'd0, IDLE});
    chk("rmem_instret", instret, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rmem_req_back", {21'd0, outs}, {21'd0, F_WAIT});

    // illegal: no bit set, sticky trap
    instr_index = 32'd0;
    cyc("trap0_f", 1, 0, F_ACK);
    cyc("trap0_d", 1, 0, DEC);
    for (int i = 0; i < 12; i++)
      cyc($sformatf("trap0_hold%0d", i), i[0], i[1], TRP);
    chk("trap0_instret", instret, 32'd0);

    // illegal: two bits set
    do_reset();
    chk("trap_cleared", {31'd0, trap}, 32'd0);
    instr_index = 32'h3;
    cyc("trap2_f", 1, 0, F_ACK);
    cyc("trap2_d", 1, 0, DEC);
    cyc("trap2_t", 1, 0, TRP);

    // illegal: bit 31 set alongside a legal bit
    do_reset();
    instr_index = 32'h8000_0001;
    cyc("trap31_f", 1, 0, F_ACK);
    cyc("trap31_d", 1, 0, DEC);
    cyc("trap31_t", 1, 0, TRP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
